// File: rtl/uart_rx_os.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx_os                                                 |
// | Description : UART receiver, 16x oversampling with 3-sample majority     |
// |               vote, configurable data/stop bits, framing and optional    |
// |               parity error flags, valid/ready output register with       |
// |               overrun pulse.                                             |
// | Options     : define UART_RX_PARITY_EN to receive one parity bit after   |
// |               the data bits (PARITY_ODD selects odd/even).               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_rx_os #(
  parameter int CLK_FREQUENCY  = 66_000_000,
  parameter int UART_FREQUENCY = 921_600,
  parameter int DATA_BITS      = 8,
  parameter int STOP_BITS      = 1,
  parameter int PARITY_ODD     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 ready,
  output logic                 valid,
  output logic [DATA_BITS-1:0] data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV = CLK_FREQUENCY / (UART_FREQUENCY * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  state_t               state;
  logic                 rx_m;
  logic                 rx_s;
  logic                 rx_s_d;
  logic [DIV_W-1:0]     div_cnt;
  logic [3:0]           sub_cnt;
  logic [3:0]           bit_cnt;
  logic                 stop_idx;
  logic                 samp7;
  logic                 samp8;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_acc;
  logic                 tick;
  logic                 mid_tick;
  logic                 end_tick;
  logic                 maj;
  logic                 perr_load;

  // The counter is held at zero in IDLE, so no tick can occur there.
  assign tick     = (state != IDLE) && (div_cnt == DIV_LAST);
  assign mid_tick = tick && (sub_cnt == 4'd9);
  assign end_tick = tick && (sub_cnt == 4'd15);
  // Third sample is the live synchronised line at the sub-count 9 tick.
  assign maj      = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);
  assign busy     = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic perr_acc;
  assign perr_load = perr_acc;
`else
  logic unused_parity_odd;
  assign perr_load         = 1'b0;
  assign unused_parity_odd = PARITY_ODD[0];
`endif

  // Two-flop synchroniser plus one delay flop for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
    end
  end

  // Receive state machine, oversampling counters and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      sub_cnt    <= '0;
      bit_cnt    <= '0;
      stop_idx   <= 1'b0;
      samp7      <= 1'b1;
      samp8      <= 1'b1;
      shreg      <= '0;
      ferr_acc   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_acc   <= 1'b0;
`endif
      valid      <= 1'b0;
      data       <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      // A consumer accept drops valid unless a completion below reloads it.
      if (valid && ready) begin
        valid <= 1'b0;
      end

      if (state == IDLE || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (tick) begin
        sub_cnt <= sub_cnt + 1'b1;
        if (sub_cnt == 4'd7) samp7 <= rx_s;
        if (sub_cnt == 4'd8) samp8 <= rx_s;
      end

      case (state)
        IDLE: begin
          // Needs a real 1->0 transition; a line stuck low never restarts.
          if (!rx_s && rx_s_d) begin
            state    <= START;
            sub_cnt  <= '0;
            stop_idx <= 1'b0;
            ferr_acc <= 1'b0;
          end
        end

        START: begin
          if (mid_tick && maj) begin
            state <= IDLE;
          end else if (end_tick) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end

        DATA: begin
          if (mid_tick) begin
            shreg <= {maj, shreg[DATA_BITS-1:1]};
          end
          if (end_tick) begin
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (mid_tick) begin
            perr_acc <= (^shreg) ^ maj ^ PARITY_ODD[0];
          end
          if (end_tick) begin
            state <= STOP;
          end
        end
`endif

        STOP: begin
          if (mid_tick) begin
            ferr_acc <= ferr_acc | ~maj;
            // Frame ends mid final stop bit so a following start edge is seen.
            if (stop_idx == LAST_STOP) begin
              state <= IDLE;
              if (!valid || ready) begin
                valid      <= 1'b1;
                data       <= shreg;
                frame_err  <= ferr_acc | ~maj;
                parity_err <= perr_load;
              end else begin
                overrun <= 1'b1;
              end
            end
          end else if (end_tick) begin
            stop_idx <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_rx_os                                              |
// | Description : Self-checking bench for uart_rx_os (DIV=2, 32 cycles/bit). |
// |               Builds with or without UART_RX_PARITY_EN.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_rx_os;

  localparam int CLK_F   = 32_000_000;
  localparam int UART_F  = 1_000_000;
  localparam int BIT_CYC = 32;
`ifdef UART_RX_PARITY_EN
  localparam int DB  = 7;
  localparam bit PAR = 1'b1;
`else
  localparam int DB  = 8;
  localparam bit PAR = 1'b0;
`endif
  localparam int SB   = 1;
  localparam int PODD = 0;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          rx    = 1'b1;
  logic          ready = 1'b1;
  logic          valid;
  logic [DB-1:0] data;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;
  logic          busy;

  uart_rx_os #(
    .CLK_FREQUENCY (CLK_F),
    .UART_FREQUENCY(UART_F),
    .DATA_BITS     (DB),
    .STOP_BITS     (SB),
    .PARITY_ODD    (PODD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .ready     (ready),
    .valid     (valid),
    .data      (data),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: words the receiver should be holding, packed as
  // {perr[17], ferr[16], data[8:0]}.
  logic [31:0] exp_q[$];
  logic [31:0] e;
  int          ovr_cnt   = 0;
  int          exp_ovr   = 0;
  int          got_words = 0;
  bit          mon_en    = 1'b0;

  // A finished frame is kept if the holding register is free, else dropped.
  task automatic model_complete(input logic [8:0] d, input logic ferr, input logic perr);
    if (exp_q.size() == 0) exp_q.push_back({14'b0, perr, ferr, 7'b0, d});
    else exp_ovr++;
  endtask

  // Every accepted word is compared against the oldest expected word.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (overrun) ovr_cnt++;
      if (valid && ready) begin
        got_words++;
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("data", 32'(data), {23'b0, e[8:0]});
          check("frame_err", 32'(frame_err), {31'b0, e[16]});
          check("parity_err", 32'(parity_err), {31'b0, e[17]});
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one complete frame; the line is left at the stop level.
  task automatic send_frame(input logic [8:0] d, input logic pbit, input logic stop_val);
    logic [8:0] dm;
    logic       perr;
    dm = '0;
    for (int i = 0; i < DB; i++) dm[i] = d[i];
    perr = PAR ? 1'(($countones(dm) + int'(pbit) + PODD) % 2) : 1'b0;
    rx = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < DB; i++) begin
      rx = dm[i];
      wait_cyc(BIT_CYC);
    end
    if (PAR) begin
      rx = pbit;
      wait_cyc(BIT_CYC);
    end
    for (int s = 0; s < SB; s++) begin
      rx = stop_val;
      if (s == SB - 1) model_complete(dm, ~stop_val, perr);
      wait_cyc(BIT_CYC);
    end
    if (ready) check("drain", exp_q.size(), 32'd0);
  endtask

  function automatic logic good_par(input logic [8:0] d);
    int n;
    n = 0;
    for (int i = 0; i < DB; i++) n += int'(d[i]);
    return 1'((n + PODD) % 2);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int words_before;
    int ovr_before;
    logic [8:0] d;
    logic sbad;
    int gap;

    // Reset state.
    wait_cyc(3);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    rst = 1'b0;
    wait_cyc(5);
    mon_en = 1'b1;

    // Two frames back to back.
    ready = 1'b1;
    send_frame(9'h0A5, good_par(9'h0A5), 1'b1);
    send_frame(9'h03C, good_par(9'h03C), 1'b1);
    rx = 1'b1;
    wait_cyc(20);
    check("b2b_words", got_words, 32'd2);

    // False start: short low pulse must not produce a word.
    words_before = got_words;
    rx = 1'b0;
    wait_cyc(8);
    check("fs_busy_high", 32'(busy), 32'd1);
    rx = 1'b1;
    for (int i = 0; i < 40 && busy; i++) wait_cyc(1);
    check("fs_busy_clear", 32'(busy), 32'd0);
    wait_cyc(40);
    check("fs_no_word", got_words, words_before);

    // Framing error followed by a line stuck low.
    words_before = got_words;
    send_frame(9'h05A, good_par(9'h05A), 1'b0);
    wait_cyc(200);
    check("ferr_one_word", got_words, words_before + 1);
    check("ferr_idle", 32'(busy), 32'd0);
    rx = 1'b1;
    wait_cyc(40);

`ifdef UART_RX_PARITY_EN
    send_frame(9'h007, 1'b0, 1'b1);
    rx = 1'b1;
    wait_cyc(10);
    send_frame(9'h007, 1'b1, 1'b1);
    rx = 1'b1;
    wait_cyc(10);
`endif

    // Randomised frames with occasional bad stop bits and random gaps.
    for (int n = 0; n < 30; n++) begin
      d    = 9'($urandom);
      sbad = ($urandom_range(0, 7) == 0);
      gap  = $urandom_range(0, 20);
      if (sbad) gap += 4;
      send_frame(d, PAR ? 1'($urandom) : 1'b0, ~sbad);
      rx = 1'b1;
      wait_cyc(gap);
    end
    wait_cyc(10);

    // Overrun: consumer stalled across two completions.
    ready = 1'b0;
    ovr_before = ovr_cnt;
    send_frame(9'h011, good_par(9'h011), 1'b1);
    rx = 1'b1;
    check("ovr_first_valid", 32'(valid), 32'd1);
    check("ovr_first_data", 32'(data), 32'h11);
    send_frame(9'h022, good_par(9'h022), 1'b1);
    rx = 1'b1;
    wait_cyc(5);
    check("ovr_data_kept", 32'(data), 32'h11);
    check("ovr_pulse", ovr_cnt, ovr_before + 1);
    ready = 1'b1;
    wait_cyc(1);
    ready = 1'b0;
    check("ovr_valid_clear", 32'(valid), 32'd0);
    wait_cyc(5);

    // Reset in the middle of a frame, with a held word pending.
    send_frame(9'h033, good_par(9'h033), 1'b1);
    rx = 1'b1;
    wait_cyc(5);
    check("mid_pending", 32'(valid), 32'd1);
    rx = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b1;
      wait_cyc(BIT_CYC);
    end
    wait_cyc(10);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_data", 32'(data), 32'd0);
    check("mid_rst_ferr", 32'(frame_err), 32'd0);
    check("mid_rst_perr", 32'(parity_err), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    wait_cyc(3);
    rx  = 1'b1;
    rst = 1'b0;
    wait_cyc(5);
    ready = 1'b1;
    words_before = got_words;
    send_frame(9'h081, good_par(9'h081), 1'b1);
    rx = 1'b1;
    wait_cyc(10);
    check("post_rst_word", got_words, words_before + 1);

    check("ovr_total", ovr_cnt, exp_ovr);
    check("words_left", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
